// File: rtl/alu_mdu_seq.sv
// Handshaked execution unit: single-cycle ALU ops plus iterative unsigned
// shift-add multiply and restoring divide, results held until consumed.
module alu_mdu_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       alu_control,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result_lo,
  output logic [WIDTH-1:0] result_hi,
  output logic             zout,
  output logic             ovf,
  output logic             illegal
);

  localparam int CNTW = $clog2(WIDTH + 1);

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_XOR  = 4'b0011;
  localparam logic [3:0] OP_NOR  = 4'b0100;
  localparam logic [3:0] OP_SLTU = 4'b0101;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_SLT  = 4'b0111;
  localparam logic [3:0] OP_MULU = 4'b1000;
  localparam logic [3:0] OP_DIVU = 4'b1001;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

  state_t               r_state, w_state_next;
  logic [WIDTH-1:0]     r_a, w_a_next;
  logic [WIDTH-1:0]     r_b, w_b_next;
  logic [2*WIDTH-1:0]   r_acc, w_acc_next;
  logic [CNTW-1:0]      r_cnt, w_cnt_next;
  logic [WIDTH-1:0]     r_lo, w_lo_next;
  logic [WIDTH-1:0]     r_hi, w_hi_next;
  logic                 r_z, w_z_next;
  logic                 r_ovf, w_ovf_next;
  logic                 r_ill, w_ill_next;

  logic [WIDTH-1:0]     w_sum, w_diff, w_alu_lo;
  logic                 w_alu_ovf, w_alu_ill;
  logic [WIDTH:0]       w_madd;
  logic [2*WIDTH-1:0]   w_mul_step;
  logic [WIDTH:0]       w_rem_sh;
  logic [WIDTH-1:0]     w_dsub;
  logic                 w_dge;
  logic [2*WIDTH-1:0]   w_div_step;
  logic                 w_last;

  assign in_ready  = (r_state == S_IDLE);
  assign out_valid = (r_state == S_DONE);
  assign result_lo = r_lo;
  assign result_hi = r_hi;
  assign zout      = r_z;
  assign ovf       = r_ovf;
  assign illegal   = r_ill;

  assign w_sum  = a + b;
  assign w_diff = a - b;

  always_comb begin
    w_alu_lo  = '0;
    w_alu_ovf = 1'b0;
    w_alu_ill = 1'b0;
    case (alu_control)
      OP_AND:  w_alu_lo = a & b;
      OP_OR:   w_alu_lo = a | b;
      OP_ADD: begin
        w_alu_lo  = w_sum;
        w_alu_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (w_sum[WIDTH-1] != a[WIDTH-1]);
      end
      OP_XOR:  w_alu_lo = a ^ b;
      OP_NOR:  w_alu_lo = ~(a | b);
      OP_SLTU: w_alu_lo = {{(WIDTH-1){1'b0}}, (a < b)};
      OP_SUB: begin
        w_alu_lo  = w_diff;
        w_alu_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (w_diff[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SLT:  w_alu_lo = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_MULU, OP_DIVU: w_alu_lo = '0;
      default: w_alu_ill = 1'b1;
    endcase
  end

  // Multiply: acc = {partial product, remaining multiplier bits}, shifted right each step.
  assign w_madd     = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_a} : '0);
  assign w_mul_step = {w_madd, r_acc[WIDTH-1:1]};

  // Divide: acc = {remainder, dividend/quotient}; quotient bits enter at the bottom.
  assign w_rem_sh   = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
  assign w_dge      = (w_rem_sh >= {1'b0, r_b});
  assign w_dsub     = w_rem_sh[WIDTH-1:0] - r_b;
  assign w_div_step = {(w_dge ? w_dsub : w_rem_sh[WIDTH-1:0]), r_acc[WIDTH-2:0], w_dge};

  assign w_last = (r_cnt == CNTW'(WIDTH - 1));

  always_comb begin
    w_state_next = r_state;
    w_a_next     = r_a;
    w_b_next     = r_b;
    w_acc_next   = r_acc;
    w_cnt_next   = r_cnt;
    w_lo_next    = r_lo;
    w_hi_next    = r_hi;
    w_z_next     = r_z;
    w_ovf_next   = r_ovf;
    w_ill_next   = r_ill;
    case (r_state)
      S_IDLE: begin
        if (in_valid) begin
          w_a_next   = a;
          w_b_next   = b;
          w_cnt_next = '0;
          if (alu_control == OP_MULU) begin
            w_acc_next   = {{WIDTH{1'b0}}, b};
            w_state_next = S_MUL;
          end else if (alu_control == OP_DIVU && b != '0) begin
            w_acc_next   = {{WIDTH{1'b0}}, a};
            w_state_next = S_DIV;
          end else if (alu_control == OP_DIVU) begin
            w_lo_next    = '1;
            w_hi_next    = a;
            w_z_next     = 1'b0;
            w_ovf_next   = 1'b0;
            w_ill_next   = 1'b0;
            w_state_next = S_DONE;
          end else begin
            w_lo_next    = w_alu_lo;
            w_hi_next    = '0;
            w_z_next     = (w_alu_lo == '0);
            w_ovf_next   = w_alu_ovf;
            w_ill_next   = w_alu_ill;
            w_state_next = S_DONE;
          end
        end
      end
      S_MUL: begin
        w_acc_next = w_mul_step;
        w_cnt_next = r_cnt + 1'b1;
        if (w_last) begin
          w_lo_next    = w_mul_step[WIDTH-1:0];
          w_hi_next    = w_mul_step[2*WIDTH-1:WIDTH];
          w_z_next     = (w_mul_step[WIDTH-1:0] == '0);
          w_ovf_next   = 1'b0;
          w_ill_next   = 1'b0;
          w_state_next = S_DONE;
        end
      end
      S_DIV: begin
        w_acc_next = w_div_step;
        w_cnt_next = r_cnt + 1'b1;
        if (w_last) begin
          w_lo_next    = w_div_step[WIDTH-1:0];
          w_hi_next    = w_div_step[2*WIDTH-1:WIDTH];
          w_z_next     = (w_div_step[WIDTH-1:0] == '0);
          w_ovf_next   = 1'b0;
          w_ill_next   = 1'b0;
          w_state_next = S_DONE;
        end
      end
      S_DONE: begin
        if (out_ready) w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_acc   <= '0;
      r_cnt   <= '0;
      r_lo    <= '0;
      r_hi    <= '0;
      r_z     <= 1'b0;
      r_ovf   <= 1'b0;
      r_ill   <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_a     <= w_a_next;
      r_b     <= w_b_next;
      r_acc   <= w_acc_next;
      r_cnt   <= w_cnt_next;
      r_lo    <= w_lo_next;
      r_hi    <= w_hi_next;
      r_z     <= w_z_next;
      r_ovf   <= w_ovf_next;
      r_ill   <= w_ill_next;
    end
  end

endmodule

// File: tb/tb_alu_mdu_seq.sv
// Bench for alu_mdu_seq: directed vector table, multi-cycle corner sequences,
// and random operations checked against an arithmetic reference model.
module tb_alu_mdu_seq;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a, b;
  logic [3:0]   alu_control;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result_lo, result_hi;
  logic         zout, ovf, illegal;

  int errors = 0;
  int checks = 0;

  alu_mdu_seq #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .alu_control(alu_control), .out_valid(out_valid),
    .out_ready(out_ready), .result_lo(result_lo), .result_hi(result_hi),
    .zout(zout), .ovf(ovf), .illegal(illegal)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]   op;
    logic [W-1:0] a, b, lo, hi;
    logic         z, ov, il;
  } vec_t;

  vec_t tbl[15];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // Reference model from plain integer arithmetic on the op semantics.
  function automatic void model(input logic [3:0] op, input logic [W-1:0] x, input logic [W-1:0] y,
                                output logic [W-1:0] lo, output logic [W-1:0] hi,
                                output logic z, output logic ov, output logic il);
    longint sx, sy, s;
    logic [63:0] p;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    lo = '0; hi = '0; ov = 1'b0; il = 1'b0;
    case (op)
      4'd0: lo = x & y;
      4'd1: lo = x | y;
      4'd2: begin lo = x + y; s = sx + sy; ov = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
      4'd3: lo = x ^ y;
      4'd4: lo = ~(x | y);
      4'd5: lo = (x < y) ? 1 : 0;
      4'd6: begin lo = x - y; s = sx - sy; ov = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
      4'd7: lo = (sx < sy) ? 1 : 0;
      4'd8: begin p = {32'd0, x} * {32'd0, y}; lo = p[31:0]; hi = p[63:32]; end
      4'd9: begin
        if (y == 0) begin lo = '1; hi = x; end
        else begin lo = x / y; hi = x % y; end
      end
      default: il = 1'b1;
    endcase
    z = (lo == 0);
  endfunction

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
  endtask

  // Issue one op, wait for the result, check it and its latency, then consume it.
  task automatic run_op(input string nm, input logic [3:0] op, input logic [W-1:0] x, input logic [W-1:0] y,
                        input logic [W-1:0] elo, input logic [W-1:0] ehi,
                        input logic ez, input logic eov, input logic eil);
    int k;
    int exp_lat;
    bit busy_bad;
    k = 0;
    while (!in_ready && k < 100) begin @(negedge clk); k++; end
    chk({nm, ".in_ready_wait"}, {63'd0, in_ready}, 64'd1);
    in_valid    = 1'b1;
    a           = x;
    b           = y;
    alu_control = op;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    a        = $urandom;
    b        = $urandom;
    k        = 0;
    busy_bad = 1'b0;
    do begin
      @(negedge clk);
      k++;
      if (!out_valid && in_ready) busy_bad = 1'b1;
    end while (!out_valid && k < 100);
    exp_lat = (op == 4'd8 || (op == 4'd9 && y != 0)) ? W + 1 : 1;
    chk({nm, ".latency"}, 64'(k), 64'(exp_lat));
    chk({nm, ".busy_in_ready"}, {63'd0, busy_bad}, 64'd0);
    chk({nm, ".lo"}, {32'd0, result_lo}, {32'd0, elo});
    chk({nm, ".hi"}, {32'd0, result_hi}, {32'd0, ehi});
    chk({nm, ".flags"}, {61'd0, zout, ovf, illegal}, {61'd0, ez, eov, eil});
    chk({nm, ".done_in_ready"}, {63'd0, in_ready}, 64'd0);
    $display("txn %s op=%0d a=%h b=%h lo=%h hi=%h z=%b ovf=%b ill=%b lat=%0d",
             nm, op, x, y, result_lo, result_hi, zout, ovf, illegal, k);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk({nm, ".return_idle"}, {62'd0, in_ready, out_valid}, 64'd2);
  endtask

  initial begin
    logic [W-1:0] rlo, rhi, ra, rb, hlo, hhi;
    logic rz, rov, ril;
    logic [3:0] rop;
    bit bp_bad;

    tbl[0]  = '{4'd2, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 32'h0, 1'b0, 1'b1, 1'b0};
    tbl[1]  = '{4'd7, 32'hFFFFFFFF, 32'h00000001, 32'h1,        32'h0, 1'b0, 1'b0, 1'b0};
    tbl[2]  = '{4'd5, 32'hFFFFFFFF, 32'h00000001, 32'h0,        32'h0, 1'b1, 1'b0, 1'b0};
    tbl[3]  = '{4'd7, 32'h80000000, 32'h7FFFFFFF, 32'h1,        32'h0, 1'b0, 1'b0, 1'b0};
    tbl[4]  = '{4'd6, 32'h5,        32'h5,        32'h0,        32'h0, 1'b1, 1'b0, 1'b0};
    tbl[5]  = '{4'd8, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 32'hFFFFFFFE, 1'b0, 1'b0, 1'b0};
    tbl[6]  = '{4'd9, 32'd100,      32'd7,        32'd14,       32'd2, 1'b0, 1'b0, 1'b0};
    tbl[7]  = '{4'd9, 32'h1234,     32'h0,        32'hFFFFFFFF, 32'h1234, 1'b0, 1'b0, 1'b0};
    tbl[8]  = '{4'd12, 32'h1234,    32'h5678,     32'h0,        32'h0, 1'b1, 1'b0, 1'b1};
    tbl[9]  = '{4'd0, 32'h0000F0F0, 32'h0000FF00, 32'h0000F000, 32'h0, 1'b0, 1'b0, 1'b0};
    tbl[10] = '{4'd4, 32'h0,        32'h0,        32'hFFFFFFFF, 32'h0, 1'b0, 1'b0, 1'b0};
    tbl[11] = '{4'd6, 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 32'h0, 1'b0, 1'b1, 1'b0};
    tbl[12] = '{4'd3, 32'hA5A5A5A5, 32'hFFFF0000, 32'h5A5AA5A5, 32'h0, 1'b0, 1'b0, 1'b0};
    tbl[13] = '{4'd1, 32'h00FF0000, 32'h0000000F, 32'h00FF000F, 32'h0, 1'b0, 1'b0, 1'b0};
    tbl[14] = '{4'd9, 32'd5,        32'd9,        32'd0,        32'd5, 1'b1, 1'b0, 1'b0};

    in_valid = 1'b0; a = '0; b = '0; alu_control = '0; out_ready = 1'b0;
    do_reset();
    chk("reset.ready_valid", {62'd0, in_ready, out_valid}, 64'd2);
    chk("reset.lo_hi", {result_lo, result_hi}, 64'd0);
    chk("reset.flags", {61'd0, zout, ovf, illegal}, 64'd0);

    for (int i = 0; i < 15; i++)
      run_op($sformatf("vec%0d", i), tbl[i].op, tbl[i].a, tbl[i].b,
             tbl[i].lo, tbl[i].hi, tbl[i].z, tbl[i].ov, tbl[i].il);

    // Backpressure: result held, new requests ignored while not consumed.
    in_valid = 1'b1; a = 32'd40; b = 32'd2; alu_control = 4'd2;
    @(posedge clk);
    #1;
    @(negedge clk);
    hlo = result_lo; hhi = result_hi;
    chk("bp.first", {32'd0, result_lo}, 64'd42);
    bp_bad = 1'b0;
    for (int c = 0; c < 5; c++) begin
      a = $urandom; b = $urandom; alu_control = 4'(c);
      @(negedge clk);
      if (!out_valid || in_ready || result_lo !== hlo || result_hi !== hhi) bp_bad = 1'b1;
    end
    chk("bp.held", {63'd0, bp_bad}, 64'd0);
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("bp.release", {62'd0, in_ready, out_valid}, 64'd2);
    $display("txn bp add 40+2 held 5 cycles lo=%h", hlo);

    // Reset during multiply iteration discards the op.
    in_valid = 1'b1; a = 32'hFFFFFFFF; b = 32'hFFFFFFFF; alu_control = 4'd8;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (10) @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_mid.ready_valid", {62'd0, in_ready, out_valid}, 64'd2);
    chk("rst_mid.lo_hi", {result_lo, result_hi}, 64'd0);
    chk("rst_mid.flags", {61'd0, zout, ovf, illegal}, 64'd0);
    $display("txn reset mid-MULU lo=%h hi=%h", result_lo, result_hi);
    run_op("post_rst_add", 4'd2, 32'd2, 32'd3, 32'd5, 32'd0, 1'b0, 1'b0, 1'b0);
    run_op("post_rst_ill", 4'b1100, 32'd7, 32'd9, 32'd0, 32'd0, 1'b1, 1'b0, 1'b1);

    for (int i = 0; i < 150; i++) begin
      rop = 4'($urandom_range(0, 15));
      ra  = ($urandom_range(0, 7) == 0) ? 32'h80000000 : $urandom;
      rb  = ($urandom_range(0, 7) == 0) ? 32'h0 : (($urandom_range(0, 3) == 0) ? 32'($urandom_range(1, 300)) : $urandom);
      model(rop, ra, rb, rlo, rhi, rz, rov, ril);
      run_op($sformatf("rnd%0d", i), rop, ra, rb, rlo, rhi, rz, rov, ril);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
